dot_prod_feeder: RTL and testbench

DOT_PROD_FEEDER -- requirements
Module: dot_prod_feeder

---
 rtl/dot_prod_feeder.sv | 127 ++++++++++++
 tb/tb_dot_prod_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_prod_feeder.sv
// Double-buffered input-vector feeder plus weight-column store for a dot-product engine.
// The shadow bank fills from a valid/ready stream while the engine reads the active bank.
module dot_prod_feeder #(
   parameter int NROW = 16,
   parameter int NCOL = 4,
   parameter int QN   = 6,
   parameter int QM   = 11,
   localparam int BITWIDTH       = QN + QM + 1,
   localparam int ADDR_BITWIDTH  = $clog2(NCOL + 1) - 1,
   localparam int LAYER_BITWIDTH = BITWIDTH * NROW
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             w_we,
   input  logic [ADDR_BITWIDTH-1:0]         w_addr,
   input  logic [LAYER_BITWIDTH-1:0]        w_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic signed [BITWIDTH-1:0]       in_data,
   input  logic                             in_last,
   input  logic                             frame_done,
   input  logic [ADDR_BITWIDTH-1:0]         colAddress,
   output logic [LAYER_BITWIDTH-1:0]        weightRow,
   output logic signed [BITWIDTH-1:0]       inputVector,
   output logic                             vec_valid,
   output logic [15:0]                      frame_cnt,
   output logic                             err_len
);

   typedef enum logic {SH_FILLING, SH_FULL} sh_state_t;
   typedef enum logic {ACT_EMPTY, ACT_LOADED} act_state_t;

   localparam logic [ADDR_BITWIDTH-1:0] LAST_PTR = ADDR_BITWIDTH'(NCOL - 1);

   logic [LAYER_BITWIDTH-1:0] w_mem_q [NCOL];

   logic [BITWIDTH-1:0]      bank_q [2][NCOL];
   logic [BITWIDTH-1:0]      bank_d [2][NCOL];
   logic [NCOL-1:0]          mask_q [2];
   logic [NCOL-1:0]          mask_d [2];
   logic                     act_sel_q, act_sel_d;
   sh_state_t                sh_q, sh_d;
   act_state_t               act_q, act_d;
   logic [ADDR_BITWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [15:0]              frame_cnt_q, frame_cnt_d;
   logic                     err_len_q, err_len_d;

   logic accept;
   logic swap;
   logic shadow_sel;

   assign shadow_sel = ~act_sel_q;
   assign accept     = in_valid && (sh_q == SH_FILLING);
   assign swap       = (sh_q == SH_FULL) && ((act_q == ACT_EMPTY) || frame_done);

   always_comb begin
      bank_d      = bank_q;
      mask_d      = mask_q;
      act_sel_d   = act_sel_q;
      sh_d        = sh_q;
      act_d       = act_q;
      wr_ptr_d    = wr_ptr_q;
      frame_cnt_d = frame_cnt_q;
      err_len_d   = err_len_q;

      if (accept) begin
         bank_d[shadow_sel][wr_ptr_q] = in_data;
         mask_d[shadow_sel][wr_ptr_q] = 1'b1;
         wr_ptr_d = wr_ptr_q + 1'b1;
         if ((wr_ptr_q == LAST_PTR) || in_last)
            sh_d = SH_FULL;
         if (in_last && (wr_ptr_q != LAST_PTR))
            err_len_d = 1'b1;
      end

      // Accept and swap are exclusive: accept needs FILLING, swap needs FULL.
      if (swap) begin
         act_sel_d           = ~act_sel_q;
         act_d               = ACT_LOADED;
         sh_d                = SH_FILLING;
         mask_d[act_sel_q]   = '0;
         wr_ptr_d            = '0;
         frame_cnt_d         = frame_cnt_q + 16'd1;
      end else if (frame_done && (act_q == ACT_LOADED)) begin
         act_d = ACT_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q[0]   <= '0;
         mask_q[1]   <= '0;
         act_sel_q   <= 1'b0;
         sh_q        <= SH_FILLING;
         act_q       <= ACT_EMPTY;
         wr_ptr_q    <= '0;
         frame_cnt_q <= '0;
         err_len_q   <= 1'b0;
      end else begin
         mask_q      <= mask_d;
         act_sel_q   <= act_sel_d;
         sh_q        <= sh_d;
         act_q       <= act_d;
         wr_ptr_q    <= wr_ptr_d;
         frame_cnt_q <= frame_cnt_d;
         err_len_q   <= err_len_d;
      end
   end

   // Payload storage carries no reset; validity is tracked by the masks.
   always_ff @(posedge clk) begin
      bank_q <= bank_d;
   end

   always_ff @(posedge clk) begin
      if (w_we)
         w_mem_q[w_addr] <= w_data;
   end

   assign weightRow   = w_mem_q[colAddress];
   assign inputVector = mask_q[act_sel_q][colAddress] ? bank_q[act_sel_q][colAddress] : '0;
   assign in_ready    = (sh_q == SH_FILLING);
   assign vec_valid   = (act_q == ACT_LOADED);
   assign frame_cnt   = frame_cnt_q;
   assign err_len     = err_len_q;

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Directed bench for dot_prod_feeder; expected vectors go through a scoreboard queue
// and are popped when the DUT presents them on the active bank.
module tb_dot_prod_feeder;

   localparam int NCOL  = 4;
   localparam int BW    = 18;
   localparam int LW    = 288;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              w_we = 1'b0;
   logic [1:0]        w_addr = '0;
   logic [LW-1:0]     w_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [BW-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              frame_done = 1'b0;
   logic [1:0]        colAddress = '0;
   logic [LW-1:0]     weightRow;
   logic signed [BW-1:0] inputVector;
   logic              vec_valid;
   logic [15:0]       frame_cnt;
   logic              err_len;

   int n_tests = 0;
   int n_fail  = 0;
   logic [BW-1:0] exp_q[$];
   logic [LW-1:0] wexp[NCOL];

   dot_prod_feeder dut (
      .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .frame_done(frame_done), .colAddress(colAddress), .weightRow(weightRow),
      .inputVector(inputVector), .vec_valid(vec_valid), .frame_cnt(frame_cnt),
      .err_len(err_len)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_vec(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = BW'(base + i);
         in_last  = (i == n - 1);
         chk("in_ready_fill", LW'(in_ready), LW'(1'b1));
         exp_q.push_back(BW'(base + i));
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int i = n; i < NCOL; i++) exp_q.push_back('0);
   endtask

   task automatic pulse_done();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
   endtask

   task automatic check_vec(input string tag);
      logic [BW-1:0] v;
      logic [BW-1:0] e;
      for (int c = 0; c < NCOL; c++) begin
         colAddress = 2'(c);
         #1;
         v = inputVector;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s scoreboard_empty observed=%0h expected=none", tag, v);
         end else begin
            e = exp_q.pop_front();
            chk(tag, LW'(v), LW'(e));
         end
      end
   endtask

   initial begin
      logic [LW-1:0] nw;
      logic [BW-1:0] v;

      for (int c = 0; c < NCOL; c++)
         for (int k = 0; k < LW / 32; k++) wexp[c][k*32 +: 32] = $urandom;
      for (int k = 0; k < LW / 32; k++) nw[k*32 +: 32] = $urandom;

      tick();
      tick();
      reset = 1'b0;
      chk("rst_in_ready", LW'(in_ready), LW'(1'b1));
      chk("rst_vec_valid", LW'(vec_valid), LW'(1'b0));
      chk("rst_frame_cnt", LW'(frame_cnt), LW'(16'd0));
      chk("rst_err_len", LW'(err_len), LW'(1'b0));
      v = inputVector;
      chk("rst_input_vector", LW'(v), LW'(0));

      // Weight columns 0..3
      for (int c = 0; c < NCOL; c++) begin
         w_we = 1'b1; w_addr = 2'(c); w_data = wexp[c];
         tick();
      end
      w_we = 1'b0;
      for (int c = 0; c < NCOL; c++) begin
         colAddress = 2'(c);
         #1;
         chk("w_col", weightRow, wexp[c]);
      end

      // Write to the column being read: old data until the edge
      colAddress = 2'd1;
      w_we = 1'b1; w_addr = 2'd1; w_data = nw;
      #1;
      chk("w_rd_old", weightRow, wexp[1]);
      tick();
      w_we = 1'b0;
      wexp[1] = nw;
      chk("w_rd_new", weightRow, wexp[1]);

      // First vector, swap into empty active bank
      send_vec(4, 5);
      chk("t1_vv_pre", LW'(vec_valid), LW'(1'b0));
      chk("t1_ready_full", LW'(in_ready), LW'(1'b0));
      tick();
      chk("t1_vec_valid", LW'(vec_valid), LW'(1'b1));
      chk("t1_frame_cnt", LW'(frame_cnt), LW'(16'd1));
      chk("t1_in_ready", LW'(in_ready), LW'(1'b1));
      colAddress = 2'd2;
      #1;
      chk("t1_weight_c2", weightRow, wexp[2]);
      check_vec("t1_vec");

      // Second vector waits in shadow; stray element ignored; frame_done swaps
      send_vec(4, 9);
      chk("t2_ready_full", LW'(in_ready), LW'(1'b0));
      chk("t2_frame_cnt_hold", LW'(frame_cnt), LW'(16'd1));
      in_valid = 1'b1; in_data = 18'd99; in_last = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      chk("t2_no_err", LW'(err_len), LW'(1'b0));
      colAddress = 2'd2;
      #1;
      v = inputVector;
      chk("t2_active_kept", LW'(v), LW'(18'd7));
      pulse_done();
      chk("t2_frame_cnt", LW'(frame_cnt), LW'(16'd2));
      chk("t2_vec_valid", LW'(vec_valid), LW'(1'b1));
      chk("t2_in_ready", LW'(in_ready), LW'(1'b1));
      check_vec("t2_vec");

      // Short vector sets err_len, missing entries read zero
      send_vec(2, 3);
      chk("t3_err_len", LW'(err_len), LW'(1'b1));
      chk("t3_ready_full", LW'(in_ready), LW'(1'b0));
      pulse_done();
      chk("t3_frame_cnt", LW'(frame_cnt), LW'(16'd3));
      check_vec("t3_vec");

      // frame_done with shadow filling empties active; repeat is ignored
      pulse_done();
      chk("t4_vv_empty", LW'(vec_valid), LW'(1'b0));
      pulse_done();
      chk("t4_vv_ignored", LW'(vec_valid), LW'(1'b0));
      chk("t4_frame_cnt_hold", LW'(frame_cnt), LW'(16'd3));
      send_vec(4, 20);
      chk("t4_vv_pre", LW'(vec_valid), LW'(1'b0));
      tick();
      chk("t4_vec_valid", LW'(vec_valid), LW'(1'b1));
      chk("t4_frame_cnt", LW'(frame_cnt), LW'(16'd4));
      chk("t4_err_sticky", LW'(err_len), LW'(1'b1));
      check_vec("t4_vec");

      // Reset mid-fill
      in_valid = 1'b1; in_data = 18'd1;
      tick();
      in_data = 18'd2;
      tick();
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_in_ready", LW'(in_ready), LW'(1'b1));
      chk("t5_vec_valid", LW'(vec_valid), LW'(1'b0));
      chk("t5_frame_cnt", LW'(frame_cnt), LW'(16'd0));
      chk("t5_err_len", LW'(err_len), LW'(1'b0));
      for (int c = 0; c < NCOL; c++) begin
         colAddress = 2'(c);
         #1;
         v = inputVector;
         chk("t5_input_zero", LW'(v), LW'(0));
      end
      colAddress = 2'd0;
      #1;
      chk("t5_weight_kept", weightRow, wexp[0]);

      // Fill restarts at entry 0 after reset; negative values pass bit-exact
      send_vec(4, -2);
      tick();
      chk("t6_frame_cnt", LW'(frame_cnt), LW'(16'd1));
      check_vec("t6_vec");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
